mem_wb_stage: RTL

//  Memory stage plus MEM/WB pipeline register, directly downstream of the EX/M latch.

---
 rtl/cpu_types_pkg.sv | 37 +++
 rtl/ll_sc_link.sv | 47 ++++
 rtl/mem_wb_stage.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: word/register aliases, opcodes, functs, memory-stage states
package cpu_types_pkg;

   localparam int WORD_WIDTH = 32;
   localparam int REG_WIDTH  = 5;

   typedef logic [WORD_WIDTH-1:0] word_t;
   typedef logic [REG_WIDTH-1:0]  regbits_t;

   typedef enum logic [5:0] {
      RTYPE = 6'h00,
      J     = 6'h02,
      JAL   = 6'h03,
      ADDIU = 6'h09,
      LW    = 6'h23,
      SW    = 6'h2B,
      LL    = 6'h30,
      SC    = 6'h38,
      HALT  = 6'h3F
   } opcode_t;

   typedef enum logic [5:0] {
      SLL  = 6'h00,
      JR   = 6'h08,
      ADDU = 6'h21,
      SUBU = 6'h23
   } funct_t;

   // Memory-stage access tracking: IDLE (nothing outstanding), REQ (waiting
   // for dhit), DONE (hit taken, upstream still stalled).
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } memstate_t;

endpackage

// File: rtl/ll_sc_link.sv
// rtl/ll_sc_link.sv - LL/SC link register with address match and snoop invalidation
//
// Ports:
//   CLK, nRST    clock, synchronous active-low reset
//   addr         address of the instruction in the memory stage
//   is_sc        instruction in the memory stage is an SC
//   ll_hit       LL read request hit this cycle (sets the link)
//   sc_retire    SC leaves the memory stage this cycle (clears the link)
//   ccinv        coherence invalidate, ccsnoopaddr = invalidated address
//   sc_fail      SC would fail: no valid link to addr, or link being invalidated now
module ll_sc_link #(
   parameter int WORD_W = 32
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic [WORD_W-1:0] addr,
   input  logic              is_sc,
   input  logic              ll_hit,
   input  logic              sc_retire,
   input  logic              ccinv,
   input  logic [WORD_W-1:0] ccsnoopaddr,
   output logic              sc_fail
);

   logic              link_valid;
   logic [WORD_W-1:0] link_addr;
   logic              snoop_kill;

   // An invalidate arriving in the same cycle as the SC already breaks the link.
   assign snoop_kill = ccinv & (ccsnoopaddr == link_addr);
   assign sc_fail    = is_sc & ~(link_valid & (link_addr == addr) & ~snoop_kill);

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         link_valid <= 1'b0;
         link_addr  <= '0;
      end else if (snoop_kill) begin
         link_valid <= 1'b0;
      end else if (sc_retire) begin
         link_valid <= 1'b0;
      end else if (ll_hit) begin
         link_valid <= 1'b1;
         link_addr  <= addr;
      end
   end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory stage and MEM/WB register with dcache handshake and LL/SC
//
// Ports:
//   CLK, nRST                 clock, synchronous active-low reset
//   advance, flush            hazard unit controls
//   *_in                      EX/M latch fields
//   dhit, dmemload            dcache completion and read data
//   ccinv, ccsnoopaddr        coherence invalidate
//   dmemREN/WEN/addr/store    dcache request (combinational)
//   mem_stall                 request outstanding without a hit
//   wdat_out..funct_out       registered WB-bound fields
module mem_wb_stage
   import cpu_types_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              advance,
   input  logic              flush,
   input  logic              dREN_in,
   input  logic              dWEN_in,
   input  logic [WORD_W-1:0] portO_in,
   input  logic [WORD_W-1:0] dmemStore_in,
   input  logic              MemtoReg_in,
   input  logic [1:0]        wdatasrc_in,
   input  logic [REG_W-1:0]  WSel_in,
   input  logic              WEN_in,
   input  logic [WORD_W-1:0] pcp4_in,
   input  logic              HALT_in,
   input  opcode_t           opcode_in,
   input  funct_t            funct_in,
   input  logic              dhit,
   input  logic [WORD_W-1:0] dmemload,
   input  logic              ccinv,
   input  logic [WORD_W-1:0] ccsnoopaddr,
   output logic              dmemREN,
   output logic              dmemWEN,
   output logic [WORD_W-1:0] dmemaddr,
   output logic [WORD_W-1:0] dmemstore,
   output logic              mem_stall,
   output logic [WORD_W-1:0] wdat_out,
   output logic [REG_W-1:0]  WSel_out,
   output logic              WEN_out,
   output logic              HALT_out,
   output opcode_t           opcode_out,
   output funct_t            funct_out
);

   memstate_t         state, next_state;
   logic              sc_fail, halted, memop, req_active, adv, is_sc;
   logic [WORD_W-1:0] load_buf, load_data, wdat;

   assign is_sc = (opcode_in == SC);

   ll_sc_link #(.WORD_W(WORD_W)) u_link (
      .CLK         (CLK),
      .nRST        (nRST),
      .addr        (portO_in),
      .is_sc       (is_sc),
      .ll_hit      ((opcode_in == LL) & dmemREN & dhit),
      .sc_retire   (is_sc & adv),
      .ccinv       (ccinv),
      .ccsnoopaddr (ccsnoopaddr),
      .sc_fail     (sc_fail)
   );

   // A failed SC and anything after a halt never reach the dcache.
   assign memop = (dREN_in | dWEN_in) & ~halted & ~sc_fail;

   // REQ keeps the request up without re-checking memop; DONE drops it so a
   // completed access is not repeated while upstream is stalled.
   assign req_active = ((state == IDLE) & memop) | (state == REQ);
   assign dmemREN    = dREN_in & req_active;
   assign dmemWEN    = dWEN_in & req_active;
   assign dmemaddr   = portO_in;
   assign dmemstore  = dmemStore_in;
   assign mem_stall  = (dmemREN | dmemWEN) & ~dhit;
   assign adv        = advance & ~mem_stall;

   always_ff @(posedge CLK) begin
      if (!nRST) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (memop & ~dhit)      next_state = REQ;
            else if (memop & ~adv)  next_state = DONE;
         end
         REQ: begin
            if (dhit) next_state = adv ? IDLE : DONE;
         end
         DONE: begin
            if (adv) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Hit data is only valid in the hit cycle; keep it for a stalled retire.
   always_ff @(posedge CLK) begin
      if (!nRST)     load_buf <= '0;
      else if (dhit) load_buf <= dmemload;
   end

   assign load_data = (state == DONE) ? load_buf : dmemload;

   always_comb begin
      wdat = portO_in;
      if (is_sc)                     wdat = {{(WORD_W-1){1'b0}}, ~sc_fail};
      else if (MemtoReg_in)          wdat = load_data;
      else if (wdatasrc_in == 2'b01) wdat = pcp4_in;
   end

   always_ff @(posedge CLK) begin
      if (!nRST || flush) begin
         wdat_out   <= '0;
         WSel_out   <= '0;
         WEN_out    <= 1'b0;
         HALT_out   <= 1'b0;
         opcode_out <= RTYPE;
         funct_out  <= SLL;
      end else if (adv) begin
         wdat_out   <= wdat;
         WSel_out   <= WSel_in;
         WEN_out    <= WEN_in;
         HALT_out   <= HALT_in | halted;
         opcode_out <= opcode_in;
         funct_out  <= funct_in;
      end
   end

   // Survives flush: once a halt has been accepted the core stays quiet.
   always_ff @(posedge CLK) begin
      if (!nRST)                          halted <= 1'b0;
      else if (adv & ~flush & HALT_in)    halted <= 1'b1;
   end

endmodule
